// File: rtl/xcvr_avmm_timeout_guard.sv
// Avalon-MM guard ahead of transceiver agents: forwards one transaction at a time, abandons stalled ones.
// Latency: command reaches m0 one cycle after s0 accept; read data returns one cycle after m0_readdatavalid.
// Backpressure: s0_waitrequest is high whenever a transaction is outstanding; m0_waitrequest holds the command.
module xcvr_avmm_timeout_guard #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    HDL_ADDR_WIDTH = 13,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(32'hDEADBEEF),
    parameter int                    CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        s0_waitrequest,
    output logic [DATA_WIDTH-1:0]       s0_readdata,
    output logic                        s0_readdatavalid,
    input  logic [HDL_ADDR_WIDTH-1:0]   s0_address,
    input  logic                        s0_read,
    input  logic                        s0_write,
    input  logic [DATA_WIDTH-1:0]       s0_writedata,
    input  logic [DATA_WIDTH/8-1:0]     s0_byteenable,
    input  logic                        m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]       m0_readdata,
    input  logic                        m0_readdatavalid,
    output logic [HDL_ADDR_WIDTH-1:0]   m0_address,
    output logic                        m0_read,
    output logic                        m0_write,
    output logic [DATA_WIDTH-1:0]       m0_writedata,
    output logic [DATA_WIDTH/8-1:0]     m0_byteenable,
    input  logic                        irq_clear,
    output logic                        timeout_irq,
    output logic [CNT_WIDTH-1:0]        timeout_count,
    output logic [HDL_ADDR_WIDTH-1:0]   timeout_addr
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CMD, ST_RDWAIT} state_t;

    state_t                      state_q, state_d;
    logic [HDL_ADDR_WIDTH-1:0]   m0_address_q, m0_address_d;
    logic [DATA_WIDTH-1:0]       m0_writedata_q, m0_writedata_d;
    logic [BEW-1:0]              m0_byteenable_q, m0_byteenable_d;
    logic                        m0_read_q, m0_read_d;
    logic                        m0_write_q, m0_write_d;
    logic                        is_read_q, is_read_d;
    logic [TW-1:0]               cnt_q, cnt_d;
    logic                        stale_q, stale_d;
    logic [DATA_WIDTH-1:0]       s0_readdata_q, s0_readdata_d;
    logic                        s0_readdatavalid_q, s0_readdatavalid_d;
    logic                        timeout_irq_q, timeout_irq_d;
    logic [CNT_WIDTH-1:0]        timeout_count_q, timeout_count_d;
    logic [HDL_ADDR_WIDTH-1:0]   timeout_addr_q, timeout_addr_d;
    logic                        timeout;

    always_comb begin
        state_d            = state_q;
        m0_address_d       = m0_address_q;
        m0_writedata_d     = m0_writedata_q;
        m0_byteenable_d    = m0_byteenable_q;
        m0_read_d          = m0_read_q;
        m0_write_d         = m0_write_q;
        is_read_d          = is_read_q;
        cnt_d              = cnt_q;
        stale_d            = stale_q;
        s0_readdata_d      = s0_readdata_q;
        s0_readdatavalid_d = 1'b0;
        timeout_count_d    = timeout_count_q;
        timeout_addr_d     = timeout_addr_q;
        timeout            = 1'b0;

        // A response owed to an abandoned read is swallowed wherever it arrives.
        if (m0_readdatavalid && stale_q) begin
            stale_d = 1'b0;
        end

        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (s0_read || s0_write) begin
                    m0_address_d    = s0_address;
                    m0_writedata_d  = s0_writedata;
                    m0_byteenable_d = s0_byteenable;
                    m0_read_d       = s0_read;
                    m0_write_d      = ~s0_read;
                    is_read_d       = s0_read;
                    cnt_d           = '0;
                    state_d         = ST_CMD;
                end
            end
            ST_CMD: begin
                cnt_d = cnt_q + TW'(1);
                if (!m0_waitrequest) begin
                    m0_read_d  = 1'b0;
                    m0_write_d = 1'b0;
                    state_d    = is_read_q ? ST_RDWAIT : ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                end
            end
            ST_RDWAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (m0_readdatavalid && !stale_q) begin
                    s0_readdata_d      = m0_readdata;
                    s0_readdatavalid_d = 1'b1;
                    state_d            = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (timeout) begin
            m0_read_d      = 1'b0;
            m0_write_d     = 1'b0;
            state_d        = ST_IDLE;
            timeout_addr_d = m0_address_q;
            if (timeout_count_q != '1) begin
                timeout_count_d = timeout_count_q + CNT_WIDTH'(1);
            end
            if (is_read_q) begin
                s0_readdata_d      = ERROR_DATA;
                s0_readdatavalid_d = 1'b1;
                stale_d            = 1'b1;
            end
        end

        timeout_irq_d = timeout | (timeout_irq_q & ~irq_clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_INIT;
            m0_address_q       <= '0;
            m0_writedata_q     <= '0;
            m0_byteenable_q    <= '0;
            m0_read_q          <= 1'b0;
            m0_write_q         <= 1'b0;
            is_read_q          <= 1'b0;
            cnt_q              <= '0;
            stale_q            <= 1'b0;
            s0_readdata_q      <= '0;
            s0_readdatavalid_q <= 1'b0;
            timeout_irq_q      <= 1'b0;
            timeout_count_q    <= '0;
            timeout_addr_q     <= '0;
        end else begin
            state_q            <= state_d;
            m0_address_q       <= m0_address_d;
            m0_writedata_q     <= m0_writedata_d;
            m0_byteenable_q    <= m0_byteenable_d;
            m0_read_q          <= m0_read_d;
            m0_write_q         <= m0_write_d;
            is_read_q          <= is_read_d;
            cnt_q              <= cnt_d;
            stale_q            <= stale_d;
            s0_readdata_q      <= s0_readdata_d;
            s0_readdatavalid_q <= s0_readdatavalid_d;
            timeout_irq_q      <= timeout_irq_d;
            timeout_count_q    <= timeout_count_d;
            timeout_addr_q     <= timeout_addr_d;
        end
    end

    assign s0_waitrequest   = (state_q != ST_IDLE);
    assign s0_readdata      = s0_readdata_q;
    assign s0_readdatavalid = s0_readdatavalid_q;
    assign m0_address       = m0_address_q;
    assign m0_read          = m0_read_q;
    assign m0_write         = m0_write_q;
    assign m0_writedata     = m0_writedata_q;
    assign m0_byteenable    = m0_byteenable_q;
    assign timeout_irq      = timeout_irq_q;
    assign timeout_count    = timeout_count_q;
    assign timeout_addr     = timeout_addr_q;

endmodule

// File: tb/tb_xcvr_avmm_timeout_guard.sv
// Directed bench for xcvr_avmm_timeout_guard with an 8-cycle timeout and a 2-bit timeout counter.
module tb_xcvr_avmm_timeout_guard;

    localparam int DW = 32;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s0_waitrequest;
    logic [DW-1:0] s0_readdata;
    logic          s0_readdatavalid;
    logic [AW-1:0] s0_address = '0;
    logic          s0_read = 1'b0;
    logic          s0_write = 1'b0;
    logic [DW-1:0] s0_writedata = '0;
    logic [3:0]    s0_byteenable = '0;
    logic          m0_waitrequest = 1'b0;
    logic [DW-1:0] m0_readdata = '0;
    logic          m0_readdatavalid = 1'b0;
    logic [AW-1:0] m0_address;
    logic          m0_read;
    logic          m0_write;
    logic [DW-1:0] m0_writedata;
    logic [3:0]    m0_byteenable;
    logic          irq_clear = 1'b0;
    logic          timeout_irq;
    logic [1:0]    timeout_count;
    logic [AW-1:0] timeout_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int rsp_n  = 0;
    int base   = 0;

    xcvr_avmm_timeout_guard #(
        .DATA_WIDTH(DW), .HDL_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8),
        .ERROR_DATA(32'hDEADBEEF), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid), .s0_address(s0_address),
        .s0_read(s0_read), .s0_write(s0_write), .s0_writedata(s0_writedata),
        .s0_byteenable(s0_byteenable), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .irq_clear(irq_clear), .timeout_irq(timeout_irq),
        .timeout_count(timeout_count), .timeout_addr(timeout_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s0_readdatavalid === 1'b1) rsp_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents one command for a single accepting edge; returns just after that edge.
    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
        chk("acc_rdy", s0_waitrequest, 0);
        s0_read = rd; s0_write = wr; s0_address = a; s0_writedata = d; s0_byteenable = be;
        tick();
        s0_read = 1'b0; s0_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ticks(2);
        chk("rst_wait",  s0_waitrequest, 1);
        chk("rst_m0rd",  m0_read, 0);
        chk("rst_m0wr",  m0_write, 0);
        chk("rst_rdv",   s0_readdatavalid, 0);
        chk("rst_irq",   timeout_irq, 0);
        chk("rst_cnt",   timeout_count, 0);
        chk("rst_taddr", timeout_addr, 0);
        chk("rst_rdata", s0_readdata, 0);
        reset = 1'b0;
        #1 chk("init_wait", s0_waitrequest, 1);
        tick();
        chk("idle_wait", s0_waitrequest, 0);

        // 1: read with agent data three cycles after command acceptance
        m0_waitrequest = 1'b0;
        base = rsp_n;
        issue(1, 0, 13'h010, 0, 0);
        chk("t1_m0rd", m0_read, 1);
        chk("t1_addr", m0_address, 13'h010);
        chk("t1_wait", s0_waitrequest, 1);
        tick();
        chk("t1_rd_drop", m0_read, 0);
        ticks(2);
        m0_readdatavalid = 1'b1; m0_readdata = 32'h12345678;
        tick();
        m0_readdatavalid = 1'b0; m0_readdata = '0;
        chk("t1_rdv",  s0_readdatavalid, 1);
        chk("t1_data", s0_readdata, 32'h12345678);
        chk("t1_idle", s0_waitrequest, 0);
        ticks(2);
        chk("t1_once", rsp_n - base, 1);
        chk("t1_cnt",  timeout_count, 0);

        // 2: write stalled five cycles by the agent
        m0_waitrequest = 1'b1;
        base = rsp_n;
        issue(0, 1, 13'h020, 32'hA5A5A5A5, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("t2_m0wr", m0_write, 1);
            chk("t2_addr", m0_address, 13'h020);
            chk("t2_data", m0_writedata, 32'hA5A5A5A5);
            chk("t2_be",   m0_byteenable, 4'hF);
            chk("t2_wait", s0_waitrequest, 1);
            tick();
        end
        m0_waitrequest = 1'b0;
        chk("t2_hold", m0_write, 1);
        tick();
        chk("t2_wr_drop", m0_write, 0);
        chk("t2_idle", s0_waitrequest, 0);
        tick();
        chk("t2_norsp", rsp_n - base, 0);
        chk("t2_cnt", timeout_count, 0);

        // 3: read to a silent agent times out; late data is discarded
        base = rsp_n;
        issue(1, 0, 13'h1FF, 0, 0);
        ticks(7);
        chk("t3_early_rdv", s0_readdatavalid, 0);
        chk("t3_early_irq", timeout_irq, 0);
        tick();
        chk("t3_rdv",   s0_readdatavalid, 1);
        chk("t3_err",   s0_readdata, 32'hDEADBEEF);
        chk("t3_irq",   timeout_irq, 1);
        chk("t3_count", timeout_count, 1);
        chk("t3_taddr", timeout_addr, 13'h1FF);
        chk("t3_idle",  s0_waitrequest, 0);
        m0_readdatavalid = 1'b1; m0_readdata = 32'hCAFE0001;
        tick();
        m0_readdatavalid = 1'b0; m0_readdata = '0;
        tick();
        chk("t3_stale_drop", rsp_n - base, 1);
        chk("t3_data_hold", s0_readdata, 32'hDEADBEEF);

        // 4: data arrives on the exact timeout cycle
        issue(1, 0, 13'h004, 0, 0);
        ticks(7);
        chk("t4_pre", s0_readdatavalid, 0);
        m0_readdatavalid = 1'b1; m0_readdata = 32'h55AA33CC;
        tick();
        m0_readdatavalid = 1'b0; m0_readdata = '0;
        chk("t4_rdv",   s0_readdatavalid, 1);
        chk("t4_data",  s0_readdata, 32'h55AA33CC);
        chk("t4_count", timeout_count, 1);
        chk("t4_irq",   timeout_irq, 1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("t4_irqclr", timeout_irq, 0);

        // 5: write held past timeout; irq_clear coincides with the timeout
        m0_waitrequest = 1'b1;
        base = rsp_n;
        issue(0, 1, 13'h0AB, 32'h11112222, 4'h3);
        ticks(7);
        chk("t5_pre",     m0_write, 1);
        chk("t5_pre_irq", timeout_irq, 0);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("t5_wr_drop", m0_write, 0);
        chk("t5_irq",     timeout_irq, 1);
        chk("t5_count",   timeout_count, 2);
        chk("t5_taddr",   timeout_addr, 13'h0AB);
        chk("t5_idle",    s0_waitrequest, 0);
        ticks(2);
        chk("t5_norsp", rsp_n - base, 0);

        // read stuck in the command phase, then counter saturation
        issue(1, 0, 13'h155, 0, 0);
        ticks(8);
        chk("sat_rd_drop", m0_read, 0);
        chk("sat_rdv",     s0_readdatavalid, 1);
        chk("sat_err",     s0_readdata, 32'hDEADBEEF);
        chk("sat_count",   timeout_count, 3);
        chk("sat_taddr",   timeout_addr, 13'h155);
        tick();
        issue(0, 1, 13'h0CC, 32'h0, 4'h1);
        ticks(8);
        chk("sat_hold",   timeout_count, 3);
        chk("sat_taddr2", timeout_addr, 13'h0CC);

        // 6: reset while waiting for read data
        m0_waitrequest = 1'b0;
        issue(1, 0, 13'h033, 0, 0);
        tick();
        base = rsp_n;
        reset = 1'b1;
        #1;
        chk("t6_wait",  s0_waitrequest, 1);
        chk("t6_m0rd",  m0_read, 0);
        chk("t6_rdv",   s0_readdatavalid, 0);
        chk("t6_count", timeout_count, 0);
        chk("t6_irq",   timeout_irq, 0);
        chk("t6_taddr", timeout_addr, 0);
        chk("t6_rdata", s0_readdata, 0);
        chk("t6_addr",  m0_address, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_norsp", rsp_n - base, 0);
        issue(1, 0, 13'h044, 0, 0);
        tick();
        m0_readdatavalid = 1'b1; m0_readdata = 32'h0F0F0F0F;
        tick();
        m0_readdatavalid = 1'b0; m0_readdata = '0;
        chk("t6_post_rdv",   s0_readdatavalid, 1);
        chk("t6_post_data",  s0_readdata, 32'h0F0F0F0F);
        chk("t6_post_count", timeout_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
